// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_ctrl
//  Description : Bimodal branch predictor with resolve-stage control.
//                A table of 2-bit saturating counters, indexed by PC[IDX+1:2],
//                gives a zero-latency taken prediction to fetch. The resolve
//                stage evaluates the branch condition, trains the table, and
//                raises a registered redirect when the fetch-time prediction
//                was wrong. Branch and mispredict statistics are kept.
//
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                fetch_pc           - lookup PC        -> pred_taken (comb.)
//                res_valid/res_pc   - resolving instruction present / its PC
//                res_want/res_cond  - condition code / compare result
//                res_pred           - prediction carried from fetch
//                res_target/res_next_pc - taken target / fall-through PC
//                res_taken, redirect, redirect_pc, cond_err - registered results
//                branch_cnt, miss_cnt - saturating statistics counters
//
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int         PC_W      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter int         CNT_W     = 16,
    parameter logic [1:0] BHT_INIT  = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [PC_W-1:0]  res_pc,
    input  logic [2:0]       res_want,
    input  logic [1:0]       res_cond,
    input  logic             res_pred,
    input  logic [PC_W-1:0]  res_target,
    input  logic [PC_W-1:0]  res_next_pc,
    output logic             res_taken,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             cond_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int         c_idx_w   = $clog2(BHT_DEPTH);
    localparam [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Compare-result encodings
    localparam logic [1:0] c_cond_gt  = 2'b00;
    localparam logic [1:0] c_cond_eq  = 2'b01;
    localparam logic [1:0] c_cond_lt  = 2'b10;
    localparam logic [1:0] c_cond_rsv = 2'b11;

    logic [1:0]         r_bht [BHT_DEPTH];
    logic               r_res_taken;
    logic               r_redirect;
    logic [PC_W-1:0]    r_redirect_pc;
    logic               r_cond_err;
    logic [CNT_W-1:0]   r_branch_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [c_idx_w-1:0] w_fetch_idx;
    logic [c_idx_w-1:0] w_res_idx;
    logic               w_accept;
    logic               w_is_cond;
    logic               w_cond_rsv;
    logic               w_taken_raw;
    logic               w_taken;
    logic               w_mispredict;
    logic               w_bht_we;
    logic [1:0]         w_bht_cur;
    logic [1:0]         w_bht_nxt;
    logic               w_unused;

    assign w_fetch_idx = fetch_pc[c_idx_w+1:2];
    assign w_res_idx   = res_pc[c_idx_w+1:2];

    // Read of the registered table: a same-cycle update is not visible here
    // until after the clock edge, so fetch always sees the pre-update value.
    assign pred_taken  = r_bht[w_fetch_idx][1];

    // While a redirect is being issued, whatever sits in resolve is wrong-path.
    assign w_accept    = res_valid & ~r_redirect;

    assign w_is_cond   = (res_want >= 3'd2);
    assign w_cond_rsv  = w_is_cond & (res_cond == c_cond_rsv);

    always_comb begin
        w_taken_raw = 1'b0;
        case (res_want)
            3'd0:    w_taken_raw = 1'b0;
            3'd1:    w_taken_raw = 1'b1;
            3'd2:    w_taken_raw = (res_cond == c_cond_lt);
            3'd3:    w_taken_raw = (res_cond == c_cond_gt) | (res_cond == c_cond_eq);
            3'd4:    w_taken_raw = (res_cond == c_cond_eq);
            3'd5:    w_taken_raw = (res_cond != c_cond_eq);
            3'd6:    w_taken_raw = (res_cond == c_cond_eq) | (res_cond == c_cond_lt);
            3'd7:    w_taken_raw = (res_cond == c_cond_gt);
            default: w_taken_raw = 1'b0;
        endcase
    end

    // A reserved compare result never produces a taken branch.
    assign w_taken      = w_taken_raw & ~w_cond_rsv;
    assign w_mispredict = w_taken ^ res_pred;

    // Only genuinely conditional branches with a trustworthy compare train.
    assign w_bht_we  = w_accept & w_is_cond & ~w_cond_rsv;
    assign w_bht_cur = r_bht[w_res_idx];

    always_comb begin
        w_bht_nxt = w_bht_cur;
        if (w_taken) begin
            if (w_bht_cur != 2'b11) w_bht_nxt = w_bht_cur + 2'd1;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_nxt = w_bht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= BHT_INIT;
        end else if (w_bht_we) begin
            r_bht[w_res_idx] <= w_bht_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_taken   <= 1'b0;
            r_redirect    <= 1'b0;
            r_cond_err    <= 1'b0;
            r_redirect_pc <= '0;
            r_branch_cnt  <= '0;
            r_miss_cnt    <= '0;
        end else if (w_accept) begin
            r_res_taken   <= w_taken;
            r_redirect    <= w_mispredict;
            r_cond_err    <= w_cond_rsv;
            r_redirect_pc <= w_taken ? res_target : res_next_pc;
            if ((res_want != 3'd0) && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + c_cnt_one;
            if (w_mispredict && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + c_cnt_one;
        end else begin
            // redirect_pc intentionally holds its last value here
            r_res_taken   <= 1'b0;
            r_redirect    <= 1'b0;
            r_cond_err    <= 1'b0;
        end
    end

    assign res_taken   = r_res_taken;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign cond_err    = r_cond_err;
    assign branch_cnt  = r_branch_cnt;
    assign miss_cnt    = r_miss_cnt;

    // PC bits outside the index field play no part in prediction.
    assign w_unused = ^{fetch_pc[PC_W-1:c_idx_w+2], fetch_pc[1:0],
                        res_pc[PC_W-1:c_idx_w+2], res_pc[1:0]};

endmodule
`default_nettype wire
